alu_cmd_seq: RTL and testbench

Command sequencer sitting directly upstream of the registered ALU: it accepts ALU commands over a valid/ready interface, buffers them, and drives the ALU's operand/function inputs one command per cycle. It captures each registered ALU result together with the class flags sampled at issue time and returns them over a second valid/ready interface. It decouples the free-running, hold-less ALU from bursty producers and back-pressuring consumers.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_cmd_seq_sync_fifo.sv | 55 +++++
 rtl/alu_cmd_seq.sv | 111 +++++++++++
 tb/tb_alu_cmd_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: ALU function codes and
// the bit layout of the four-bit class-flag vector returned with each result.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ADD      = 4'd0,
    SUB      = 4'd1,
    MUL      = 4'd2,
    DIV      = 4'd3,
    AND      = 4'd4,
    OR       = 4'd5,
    NAND     = 4'd6,
    NOR      = 4'd7,
    XOR      = 4'd8,
    XNOR     = 4'd9,
    CMP_EQ   = 4'd10,
    CMP_GT   = 4'd11,
    CMP_LT   = 4'd12,
    SHR      = 4'd13,
    SHL      = 4'd14,
    IDLE_FUN = 4'd15
  } alu_fun_e;

  localparam int FLAG_W     = 4;
  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;

endpackage

// File: rtl/alu_cmd_seq_sync_fifo.sv
// Single-clock FIFO with storage held in flops and a read port taken straight
// from the head entry; push and pop may coincide at any fill level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is only allowed when the head leaves in the same cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of the registered ALU: queues commands, issues one
// per cycle when result space is reserved, and queues each result with its flags.
module alu_cmd_seq
  import alu_seq_pkg::*;
#(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_fun,
  input  logic [n:0]          cmd_a,
  input  logic [n:0]          cmd_b,
  output logic [n:0]          ALU_A,
  output logic [n:0]          ALU_B,
  output logic [3:0]          ALU_FUN,
  input  logic [n+1:0]        ALU_OUT,
  input  logic                Arith_Flag,
  input  logic                Logic_Flag,
  input  logic                CMP_Flag,
  input  logic                Shift_Flag,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [n+1:0]        res_data,
  output logic [FLAG_W-1:0]   res_flags
);

  localparam int CW   = 4 + 2 * (n + 1);
  localparam int RW   = n + 2 + FLAG_W;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [CNTW:0] OCC_LIMIT = (CNTW+1)'(DEPTH);

  logic [CW-1:0]     cmd_head;
  logic              cmd_full;
  logic              cmd_empty;
  logic [CNTW-1:0]   unused_cmd_count;
  logic [RW-1:0]     res_head;
  logic              res_empty;
  logic              unused_res_full;
  logic [CNTW-1:0]   res_count;
  logic              in_flight;
  logic              issue;
  logic [CNTW:0]     occupancy;
  logic [FLAG_W-1:0] flag_now;
  logic [FLAG_W-1:0] flag_reg;

  assign cmd_ready = ~cmd_full & ~RST;
  assign occupancy = {1'b0, res_count} + {{CNTW{1'b0}}, in_flight};
  assign issue     = ~RST & ~cmd_empty & (occupancy < OCC_LIMIT);

  sync_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (cmd_valid & cmd_ready),
    .wr_data ({cmd_fun, cmd_a, cmd_b}),
    .rd_en   (issue),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   (unused_cmd_count)
  );

  // The ALU has no hold input, so it sees the idle code whenever nothing issues.
  always_comb begin
    ALU_FUN = IDLE_FUN;
    ALU_A   = '0;
    ALU_B   = '0;
    if (issue) begin
      {ALU_FUN, ALU_A, ALU_B} = cmd_head;
    end
  end

  always_comb begin
    flag_now             = '0;
    flag_now[FLAG_ARITH] = Arith_Flag;
    flag_now[FLAG_LOGIC] = Logic_Flag;
    flag_now[FLAG_CMP]   = CMP_Flag;
    flag_now[FLAG_SHIFT] = Shift_Flag;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_flight <= 1'b0;
      flag_reg  <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        flag_reg <= flag_now;
      end
    end
  end

  sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (in_flight & ~RST),
    .wr_data ({ALU_OUT, flag_reg}),
    .rd_en   (res_ready & res_valid),
    .rd_data (res_head),
    .full    (unused_res_full),
    .empty   (res_empty),
    .count   (res_count)
  );

  assign res_valid = ~res_empty;
  assign res_data  = res_empty ? '0 : res_head[RW-1:FLAG_W];
  assign res_flags = res_empty ? '0 : res_head[FLAG_W-1:0];

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a small registered-ALU model closing the loop.
module tb_alu_cmd_seq;
  import alu_seq_pkg::*;

  logic        CLK;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_fun;
  logic [16:0] cmd_a;
  logic [16:0] cmd_b;
  logic [16:0] ALU_A;
  logic [16:0] ALU_B;
  logic [3:0]  ALU_FUN;
  logic [17:0] ALU_OUT;
  logic        Arith_Flag;
  logic        Logic_Flag;
  logic        CMP_Flag;
  logic        Shift_Flag;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] res_data;
  logic [3:0]  res_flags;

  int checks = 0;
  int errors = 0;
  int accepted;

  alu_cmd_seq #(.n(16), .DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_fun    (cmd_fun),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered ALU: shifts act on its own previous output, idle clears it.
  function automatic logic [17:0] alu_calc(input logic [3:0] f, input logic [16:0] a,
                                           input logic [16:0] b, input logic [17:0] prev);
    case (f)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd4:    return {1'b0, a & b};
      4'd8:    return {1'b0, a ^ b};
      4'd10:   return (a == b) ? 18'd1 : 18'd0;
      4'd11:   return (a > b) ? 18'd2 : 18'd0;
      4'd12:   return (a < b) ? 18'd3 : 18'd0;
      4'd13:   return prev >> 1;
      4'd14:   return prev << 1;
      default: return 18'd0;
    endcase
  endfunction

  always @(posedge CLK) ALU_OUT <= alu_calc(ALU_FUN, ALU_A, ALU_B, ALU_OUT);

  assign Arith_Flag = (ALU_FUN <= 4'd3);
  assign Logic_Flag = (ALU_FUN >= 4'd4) && (ALU_FUN <= 4'd9);
  assign CMP_Flag   = (ALU_FUN >= 4'd10) && (ALU_FUN <= 4'd12);
  assign Shift_Flag = (ALU_FUN == 4'd13) || (ALU_FUN == 4'd14);

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one command for one cycle; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [3:0] f, input logic [16:0] a, input logic [16:0] b);
    cmd_valid = 1'b1;
    cmd_fun   = f;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [17:0] exp_data,
                             input logic [3:0] exp_flags, input int max_cycles);
    bit found = 0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge CLK);
      if (res_valid) begin
        found = 1;
        check_output({tag, "_data"}, res_data, exp_data);
        check_output({tag, "_flags"}, res_flags, exp_flags);
      end
      @(posedge CLK); #1;
    end
    check_output({tag, "_arrived"}, found, 1);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (res_valid) seen++;
      @(posedge CLK); #1;
    end
    check_output(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_fun   = 4'd0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;

    @(negedge CLK);
    check_output("rst_cmd_ready", cmd_ready, 0);
    check_output("rst_alu_fun", ALU_FUN, 15);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_output("post_rst_cmd_ready", cmd_ready, 1);
    check_output("post_rst_res_valid", res_valid, 0);
    check_output("post_rst_res_data", res_data, 0);
    check_output("post_rst_res_flags", res_flags, 0);
    check_output("post_rst_alu_fun", ALU_FUN, 15);
    check_output("post_rst_alu_ab", {ALU_A, ALU_B}, 0);
    @(posedge CLK); #1;

    $display("[TB] ADD latency");
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_fun = ADD; cmd_a = 17'd5; cmd_b = 17'd3;
    @(negedge CLK);
    check_output("lat_t_ready", cmd_ready, 1);
    check_output("lat_t_valid", res_valid, 0);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    @(negedge CLK);
    check_output("lat_t1_fun", ALU_FUN, 0);
    check_output("lat_t1_a", ALU_A, 5);
    check_output("lat_t1_b", ALU_B, 3);
    check_output("lat_t1_valid", res_valid, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("lat_t2_valid", res_valid, 0);
    check_output("lat_t2_idle_fun", ALU_FUN, 15);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("lat_t3_valid", res_valid, 1);
    check_output("lat_t3_data", res_data, 8);
    check_output("lat_t3_flags", res_flags, 4'b1000);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("lat_t4_valid", res_valid, 0);
    @(posedge CLK); #1;

    $display("[TB] SUB wrap");
    apply_stimulus(SUB, 17'd3, 17'd5);
    wait_result("sub", 18'h3FFFE, 4'b1000, 10);

    $display("[TB] ADD then SHL back-to-back");
    apply_stimulus(ADD, 17'd5, 17'd3);
    apply_stimulus(SHL, 17'd0, 17'd0);
    wait_result("chain_add", 18'd8, 4'b1000, 10);
    wait_result("chain_shl", 18'd16, 4'b0001, 10);

    $display("[TB] ADD, bubble, SHL");
    apply_stimulus(ADD, 17'd5, 17'd3);
    @(posedge CLK); #1;
    apply_stimulus(SHL, 17'd0, 17'd0);
    wait_result("bubble_add", 18'd8, 4'b1000, 10);
    wait_result("bubble_shl", 18'd0, 4'b0001, 10);

    $display("[TB] CMP_GT and SHR after idle");
    apply_stimulus(CMP_GT, 17'd9, 17'd4);
    wait_result("cmp_gt", 18'd2, 4'b0010, 10);
    apply_stimulus(SHR, 17'd0, 17'd0);
    wait_result("shr_idle", 18'd0, 4'b0001, 10);

    $display("[TB] Back-pressure fill");
    res_ready = 1'b0;
    accepted  = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cmd_fun = ADD;
      cmd_a   = 17'(3 * accepted + 1);
      cmd_b   = 17'(accepted);
      @(negedge CLK);
      if (cmd_ready) accepted++;
      @(posedge CLK); #1;
    end
    cmd_valid = 1'b0;
    @(negedge CLK);
    check_output("fill_accepted", accepted, 8);
    check_output("fill_cmd_ready", cmd_ready, 0);
    check_output("fill_res_valid", res_valid, 1);
    check_output("fill_head_data", res_data, 1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("stall_valid_stable", res_valid, 1);
    check_output("stall_data_stable", res_data, 1);
    check_output("stall_flags_stable", res_flags, 4'b1000);
    @(posedge CLK); #1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_result($sformatf("drain%0d", i), 18'(4 * i + 1), 4'b1000, 20);
    end
    check_quiet("drain_no_dup", 6);

    $display("[TB] Reset mid-operation");
    res_ready = 1'b0;
    apply_stimulus(ADD, 17'd1, 17'd1);
    apply_stimulus(ADD, 17'd2, 17'd2);
    apply_stimulus(ADD, 17'd3, 17'd3);
    apply_stimulus(ADD, 17'd4, 17'd4);
    @(negedge CLK);
    check_output("pre_rst_valid", res_valid, 1);
    check_output("pre_rst_head", res_data, 2);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_output("mid_rst_cmd_ready", cmd_ready, 0);
    check_output("mid_rst_alu_fun", ALU_FUN, 15);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_output("after_rst_valid", res_valid, 0);
    check_output("after_rst_data", res_data, 0);
    check_output("after_rst_alu_fun", ALU_FUN, 15);
    check_output("after_rst_cmd_ready", cmd_ready, 1);
    @(posedge CLK); #1;
    res_ready = 1'b1;
    apply_stimulus(ADD, 17'd5, 17'd3);
    wait_result("post_rst_add", 18'd8, 4'b1000, 10);
    check_quiet("post_rst_single", 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
